// File: rtl/pdp_pkg.sv
// pdp_pkg
//   Shared encodings and defaults for the PDP control unit, its memory
//   responder, and the bench that drives them.
//   - PDP_DW / PDP_AW : default data and address widths
//   - WAIT_W          : width of the wait-state counter (supports 0..15)
//   - resp_state_t    : responder FSM states
//   - mem_op_t        : latched request type
package pdp_pkg;

    localparam int PDP_DW = 8;
    localparam int PDP_AW = 5;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } resp_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } mem_op_t;

endpackage

// File: rtl/pdp_ram_sp.sv
// pdp_ram_sp
//   Single-port word array with a synchronous write and a registered read.
//   The read register only updates when re_i is high, so it holds the last
//   read result between reads. Array contents are never reset.
//   Ports:
//     clk      rising-edge clock
//     rst_n    synchronous active-low reset (read register only)
//     we_i     write enable
//     re_i     read enable (loads the read register)
//     addr_i   word address
//     wdata_i  write data
//     rdata_o  registered read data
module pdp_ram_sp #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pdp_mem_responder.sv
// pdp_mem_responder
//   Memory-side responder for the PDP control unit. Accepts one read or
//   write in IDLE, waits WAIT cycles, then commits the access on the edge
//   entering RESP and pulses ready for one cycle. A preload port writes the
//   array while the CPU side is idle.
//   Ports:
//     clk, rst_n              clock, synchronous active-low reset
//     mem_read, mem_write     request lines, held until ready
//     addr, wdata             request address / write data
//     rdata                   read data, held until the next read completes
//     ready                   one-cycle completion pulse
//     busy                    high whenever the FSM is not in IDLE
//     err                     both request lines high while IDLE
//     ld_en, ld_addr, ld_data preload write port
module pdp_mem_responder
    import pdp_pkg::*;
#(
    parameter int DW   = PDP_DW,
    parameter int AW   = PDP_AW,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ready,
    output logic          busy,
    output logic          err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data
);

    localparam logic [WAIT_W-1:0] WAIT_CNT = WAIT_W'(WAIT);

    resp_state_t       state_q;
    logic [WAIT_W-1:0] cnt_q;
    logic [AW-1:0]     lat_addr_q;
    logic [DW-1:0]     lat_wdata_q;
    mem_op_t           op_q;
    logic              ready_q;
    logic              busy_q;

    logic          idle, accept, go_resp;
    mem_op_t       cpu_op, fin_op;
    logic [AW-1:0] fin_addr, ram_addr;
    logic [DW-1:0] fin_wdata, ram_wdata;
    logic          ram_we, ram_re;

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle && (mem_read ^ mem_write);
    assign cpu_op = mem_write ? OP_WR : OP_RD;

    // With WAIT=0 the commit happens on the accept edge itself, so the
    // access must come straight from the request inputs rather than the
    // latches, which are only loaded on that same edge.
    assign go_resp   = (accept && (WAIT == 0)) ||
                       ((state_q == ST_WAIT) && (cnt_q == WAIT_W'(1)));
    assign fin_op    = idle ? cpu_op : op_q;
    assign fin_addr  = idle ? addr   : lat_addr_q;
    assign fin_wdata = idle ? wdata  : lat_wdata_q;

    // CPU commit owns the RAM port; preload only when the CPU side is
    // completely quiet. Gating with rst_n drops a commit that coincides
    // with reset.
    assign ram_we    = rst_n && ((go_resp && (fin_op == OP_WR)) ||
                                 (idle && !mem_read && !mem_write && ld_en));
    assign ram_re    = rst_n && go_resp && (fin_op == OP_RD);
    assign ram_addr  = go_resp ? fin_addr  : ld_addr;
    assign ram_wdata = go_resp ? fin_wdata : ld_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            op_q        <= OP_RD;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ready_q <= go_resp;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        lat_addr_q  <= addr;
                        lat_wdata_q <= wdata;
                        op_q        <= cpu_op;
                        cnt_q       <= WAIT_CNT;
                        busy_q      <= 1'b1;
                        state_q     <= (WAIT == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == WAIT_W'(1)) state_q <= ST_RESP;
                    else                     cnt_q   <= cnt_q - WAIT_W'(1);
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    pdp_ram_sp #(.DW(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (rdata)
    );

    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = rst_n && idle && mem_read && mem_write;

endmodule

// File: tb/tb_pdp_mem_responder.sv
module tb_pdp_mem_responder;
    import pdp_pkg::*;

    localparam int DW = 8;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst2_n, rst0_n;
    logic          mem_read, mem_write, ld_en;
    logic [AW-1:0] addr, ld_addr;
    logic [DW-1:0] wdata, ld_data;
    logic [DW-1:0] rdata2, rdata0;
    logic          ready2, ready0, busy2, busy0, err2, err0;

    // Two instances share the stimulus; the one not under test is held in reset.
    pdp_mem_responder #(.DW(DW), .AW(AW), .WAIT(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata2), .ready(ready2), .busy(busy2),
        .err(err2), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    pdp_mem_responder #(.DW(DW), .AW(AW), .WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0),
        .err(err0), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    int            wsel;
    logic [DW-1:0] c_rdata;
    logic          c_ready, c_busy, c_err;
    assign c_rdata = (wsel == 0) ? rdata0 : rdata2;
    assign c_ready = (wsel == 0) ? ready0 : ready2;
    assign c_busy  = (wsel == 0) ? busy0  : busy2;
    assign c_err   = (wsel == 0) ? err0   : err2;

    int n_pass = 0;
    int n_tot  = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; ld_en = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Request was first driven in cycle 0; k0 is the cycle of the next negedge.
    task automatic wait_ready(input string name, input int exp_lat, input bit is_rd, input int k0);
        int  k;
        bit  got;
        got = 1'b0;
        for (k = k0; k < k0 + 40; k++) begin
            @(negedge clk);
            if (c_ready) begin
                got = 1'b1;
                break;
            end
            chk({name, " busy"}, c_busy, (k >= 1));
        end
        if (!got) begin
            chk({name, " ready seen"}, 0, 1);
        end else begin
            chk({name, " latency"}, k, exp_lat);
            chk({name, " busy@ready"}, c_busy, 1);
            chk({name, " err@ready"}, c_err, 0);
            if (is_rd) begin
                if (exp_q.size() == 0) chk({name, " scoreboard empty"}, 0, 1);
                else chk({name, " rdata"}, c_rdata, exp_q.pop_front());
            end
        end
    endtask

    task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp, input string name);
        @(posedge clk); #1;
        ld_en = 1'b0; mem_read = !wr; mem_write = wr; addr = a; wdata = d;
        if (!wr) exp_q.push_back(exp);
        wait_ready(name, wsel + 1, !wr, 0);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 9; i++)
            txn(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp, $sformatf("%s vec%0d", tag, i));
    endtask

    initial begin
        int nrdy;
        tbl[0] = '{1'b0, 5'd5,  8'h00, 8'hA7};
        tbl[1] = '{1'b1, 5'd9,  8'h3C, 8'h00};
        tbl[2] = '{1'b0, 5'd9,  8'h00, 8'h3C};
        tbl[3] = '{1'b1, 5'd31, 8'hE1, 8'h00};
        tbl[4] = '{1'b0, 5'd31, 8'h00, 8'hE1};
        tbl[5] = '{1'b1, 5'd0,  8'h5A, 8'h00};
        tbl[6] = '{1'b1, 5'd0,  8'hA5, 8'h00};
        tbl[7] = '{1'b0, 5'd0,  8'h00, 8'hA5};
        tbl[8] = '{1'b0, 5'd5,  8'h00, 8'hA7};

        mem_read = 0; mem_write = 0; addr = '0; wdata = '0;
        ld_en = 0; ld_addr = '0; ld_data = '0;
        rst2_n = 0; rst0_n = 0; wsel = 2;
        repeat (3) @(posedge clk);
        #1 rst2_n = 1;
        @(negedge clk);
        chk("w2 reset rdata", rdata2, 0);
        chk("w2 reset ready", ready2, 0);
        chk("w2 reset busy",  busy2,  0);
        chk("w2 reset err",   err2,   0);

        preload(5, 8'hA7);
        run_table("w2");
        idle_cycle();

        // both requests together: err pulse, nothing accepted or written
        @(posedge clk); #1;
        mem_read = 1; mem_write = 1; addr = 5; wdata = 8'hFF;
        @(negedge clk);
        chk("both err",   c_err,   1);
        chk("both ready", c_ready, 0);
        chk("both busy",  c_busy,  0);
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
        @(negedge clk);
        chk("both err drop", c_err,   0);
        chk("both busy2",    c_busy,  0);
        chk("both ready2",   c_ready, 0);
        txn(0, 5, 8'h00, 8'hA7, "after both");

        // inputs change and request drops during WAIT; latched write still commits
        preload(3, 8'hC3);
        @(posedge clk); #1;
        mem_write = 1; mem_read = 0; addr = 2; wdata = 8'h11;
        @(posedge clk); #1;
        addr = 3; wdata = 8'hFF;
        @(posedge clk); #1;
        mem_write = 0;
        wait_ready("drop", 3, 0, 2);
        txn(0, 2, 8'h00, 8'h11, "drop rd2");
        txn(0, 3, 8'h00, 8'hC3, "drop rd3");

        // reset in WAIT discards the pending write
        preload(7, 8'h00);
        @(posedge clk); #1;
        mem_write = 1; mem_read = 0; addr = 7; wdata = 8'h55;
        @(posedge clk); #1;
        rst2_n = 0;
        @(posedge clk); #1;
        mem_write = 0; rst2_n = 1;
        @(negedge clk);
        chk("rst busy",  c_busy,  0);
        chk("rst ready", c_ready, 0);
        chk("rst rdata", c_rdata, 0);
        nrdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (c_ready) nrdy++;
        end
        chk("rst no ready", nrdy, 0);
        txn(0, 7, 8'h00, 8'h00, "rst rd7");

        // preload coinciding with a CPU read is ignored
        preload(4, 8'h66);
        @(posedge clk); #1;
        mem_read = 1; mem_write = 0; addr = 4;
        ld_en = 1; ld_addr = 4; ld_data = 8'h99;
        exp_q.push_back(8'h66);
        @(posedge clk); #1;
        ld_en = 0;
        wait_ready("ld+rd", 3, 1, 1);
        txn(0, 4, 8'h00, 8'h66, "ld+rd again");
        idle_cycle();

        // WAIT=0 instance
        @(posedge clk); #1;
        rst2_n = 0; rst0_n = 1; wsel = 0;
        @(negedge clk);
        chk("w0 reset rdata", rdata0, 0);
        chk("w0 reset ready", ready0, 0);
        chk("w0 reset busy",  busy0,  0);
        chk("w0 reset err",   err0,   0);
        preload(5, 8'hA7);
        run_table("w0");
        idle_cycle();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
